// File: rtl/rr_select_ctrl_if.sv
// -----------------------------------------------------------------------------
// rr_select_ctrl_if
// Bundles the select path (REQ in, S/GNT out) and the captured-data path
// (Y in, DOUT/DVALID out, DREADY in) of the round-robin select controller.
//
// Parameter:
//   n       - data width, must equal the 4x1 mux width
// Signals:
//   REQ     - per-channel request, bit0 = A ... bit3 = D
//   Y       - mux output, combinational from mux inputs and S
//   S       - registered mux select (00=A .. 11=D)
//   GNT     - registered one-hot grant matching S, 0000 when idle
//   DOUT    - captured data word
//   DVALID  - DOUT holds an unconsumed word
//   DREADY  - downstream accepts DOUT when DVALID & DREADY
// Modports:
//   master  - the controller side
//   slave   - the requesters / mux / downstream side
// -----------------------------------------------------------------------------
interface rr_select_ctrl_if #(
  parameter int n = 4
);
  logic [3:0]   REQ;
  logic [n-1:0] Y;
  logic [1:0]   S;
  logic [3:0]   GNT;
  logic [n-1:0] DOUT;
  logic         DVALID;
  logic         DREADY;

  modport master (
    input  REQ, Y, DREADY,
    output S, GNT, DOUT, DVALID
  );

  modport slave (
    output REQ, Y, DREADY,
    input  S, GNT, DOUT, DVALID
  );
endinterface

// File: rtl/rr_select_ctrl.sv
// -----------------------------------------------------------------------------
// rr_select_ctrl
// Round-robin select controller and capture register for a 4-channel n-bit
// mux. A grant loads S/GNT, the following edge captures Y into DOUT once S has
// been stable for a full cycle, and the word is then held under DVALID until
// DREADY takes it.
//
// Ports:
//   CLK     - sole clock, rising edge
//   RST     - synchronous active-high reset
//   io_bus  - rr_select_ctrl_if.master (REQ, Y, DREADY in; S, GNT, DOUT,
//             DVALID out, all outputs registered)
//
// Configuration macro:
//   RR_SELECT_FIXED_PRI_EN - when defined, arbitration is fixed priority
//                            A > B > C > D; LAST is still tracked but unused.
//                            Undefined (default) gives round-robin.
// -----------------------------------------------------------------------------
module rr_select_ctrl #(
  parameter int n = 4
) (
  input  logic              CLK,
  input  logic              RST,
  rr_select_ctrl_if.master  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SAMPLE = 2'b01,
    ST_OUT    = 2'b10
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_s;
  logic [1:0]   w_s_nxt;
  logic [1:0]   r_last;
  logic [1:0]   w_last_nxt;
  logic [3:0]   r_gnt;
  logic [3:0]   w_gnt_nxt;
  logic [n-1:0] r_dout;
  logic [n-1:0] w_dout_nxt;
  logic         r_dvalid;
  logic         w_dvalid_nxt;
  logic [2:0]   w_pick;

  // Returns {found, index}. The loop walks from lowest to highest priority so
  // the last hit wins.
  function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = 2'b00;
`ifdef RR_SELECT_FIXED_PRI_EN
    for (int i = 3; i >= 0; i--) begin
      idx = 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
`else
    // Offsets 4..1 from LAST; offset 4 wraps back onto LAST itself.
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
`endif
    return res;
  endfunction

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign w_pick = f_pick(io_bus.REQ, r_last);

  // Next-state and next-output decode for the IDLE/SAMPLE/OUT controller.
  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_gnt_nxt    = r_gnt;
    w_dout_nxt   = r_dout;
    w_dvalid_nxt = r_dvalid;
    w_last_nxt   = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_s_nxt     = w_pick[1:0];
          w_gnt_nxt   = f_onehot(w_pick[1:0]);
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        // S has been stable for the whole cycle, so Y is settled here.
        w_dout_nxt   = io_bus.Y;
        w_dvalid_nxt = 1'b1;
        w_last_nxt   = r_s;
        w_state_nxt  = ST_OUT;
      end
      ST_OUT: begin
        if (io_bus.DREADY) begin
          w_dvalid_nxt = 1'b0;
          w_gnt_nxt    = 4'b0000;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt  = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; RST discards any in-flight word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_s      <= 2'b00;
      r_gnt    <= 4'b0000;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_last   <= 2'b11;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_gnt    <= w_gnt_nxt;
      r_dout   <= w_dout_nxt;
      r_dvalid <= w_dvalid_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign io_bus.S      = r_s;
  assign io_bus.GNT    = r_gnt;
  assign io_bus.DOUT   = r_dout;
  assign io_bus.DVALID = r_dvalid;

endmodule

// File: tb/tb_rr_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_select_ctrl
// Directed bench for rr_select_ctrl. Stimulus pushes the expected delivered
// word (channel + mux data) into a scoreboard queue; a monitor pops and checks
// it whenever a DVALID & DREADY handshake is presented. Cycle-level checks of
// grants, timing, backpressure and reset are made inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_rr_select_ctrl;

  logic CLK;
  logic RST;

  rr_select_ctrl_if #(.n(4)) bus ();

  rr_select_ctrl #(.n(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .io_bus (bus)
  );

  typedef struct {
    logic [1:0] ch;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] md[4];
  int         n_vec;
  int         n_err;

`ifdef RR_SELECT_FIXED_PRI_EN
  localparam logic [1:0] FAIR_SEQ[5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [1:0] WRAP_CH     = 2'd0;
`else
  localparam logic [1:0] FAIR_SEQ[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic [1:0] WRAP_CH     = 2'd3;
`endif

  // 4x1 mux model feeding Y from the DUT select.
  assign bus.Y = md[bus.S];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_word(input logic [1:0] ch);
    exp_t e;
    e.ch   = ch;
    e.data = md[ch];
    sb.push_back(e);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && bus.DVALID && bus.DREADY) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got DOUT %0h S %0h with nothing expected", bus.DOUT, bus.S);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_S",    8'(bus.S),    8'(e.ch));
        chk("mon_GNT",  8'(bus.GNT),  8'(4'b0001 << e.ch));
        chk("mon_DOUT", 8'(bus.DOUT), 8'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    md[0] = 4'h3;
    md[1] = 4'h5;
    md[2] = 4'hA;
    md[3] = 4'h6;
    RST        = 1'b1;
    bus.REQ    = 4'b1111;
    bus.DREADY = 1'b1;

    // Reset held 2 cycles with all requests up.
    tick();
    tick();
    chk("rst_S",      8'(bus.S),      8'h00);
    chk("rst_GNT",    8'(bus.GNT),    8'h00);
    chk("rst_DOUT",   8'(bus.DOUT),   8'h00);
    chk("rst_DVALID", 8'(bus.DVALID), 8'h00);
    RST = 1'b0;
    expect_word(2'd0);
    tick();
    chk("first_GNT", 8'(bus.GNT), 8'h01);
    bus.REQ = 4'b0000;
    tick();
    tick();
    chk("first_done", 8'(bus.DVALID), 8'h00);

    // Single request on channel C.
    bus.REQ = 4'b0100;
    expect_word(2'd2);
    tick();
    chk("single_S",   8'(bus.S),   8'h02);
    chk("single_GNT", 8'(bus.GNT), 8'h04);
    bus.REQ = 4'b0000;
    tick();
    chk("single_DOUT",   8'(bus.DOUT),   8'h0A);
    chk("single_DVALID", 8'(bus.DVALID), 8'h01);
    tick();
    chk("single_DVALID_fall", 8'(bus.DVALID), 8'h00);
    chk("single_GNT_fall",    8'(bus.GNT),    8'h00);

    // Fairness from reset: one grant every 3 cycles with REQ=1111.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_word(FAIR_SEQ[g]);
      tick();
      chk("fair_GNT", 8'(bus.GNT), 8'(4'b0001 << FAIR_SEQ[g]));
      tick();
      chk("fair_DVALID", 8'(bus.DVALID), 8'h01);
      tick();
      chk("fair_gap", 8'(bus.GNT), 8'h00);
    end
    bus.REQ = 4'b0000;

    // Wrap with LAST=00 and REQ=1001, then 5 cycles of backpressure.
    bus.REQ    = 4'b1001;
    bus.DREADY = 1'b0;
    expect_word(WRAP_CH);
    tick();
    chk("wrap_GNT", 8'(bus.GNT), 8'(4'b0001 << WRAP_CH));
    bus.REQ = 4'b0000;
    tick();
    bus.REQ = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_DVALID", 8'(bus.DVALID), 8'h01);
      chk("bp_DOUT",   8'(bus.DOUT),   8'(md[WRAP_CH]));
      chk("bp_S",      8'(bus.S),      8'(WRAP_CH));
      chk("bp_GNT",    8'(bus.GNT),    8'(4'b0001 << WRAP_CH));
    end
    bus.REQ    = 4'b0000;
    bus.DREADY = 1'b1;
    tick();
    chk("bp_release", 8'(bus.DVALID), 8'h00);

    // Reset while holding a word in OUT: word is discarded.
    bus.REQ    = 4'b0010;
    bus.DREADY = 1'b0;
    tick();
    chk("mid_GNT", 8'(bus.GNT), 8'h02);
    bus.REQ = 4'b0000;
    tick();
    chk("mid_DVALID", 8'(bus.DVALID), 8'h01);
    RST = 1'b1;
    tick();
    chk("mid_rst_DVALID", 8'(bus.DVALID), 8'h00);
    chk("mid_rst_GNT",    8'(bus.GNT),    8'h00);
    chk("mid_rst_S",      8'(bus.S),      8'h00);
    RST        = 1'b0;
    bus.REQ    = 4'b1111;
    bus.DREADY = 1'b1;
    expect_word(2'd0);
    tick();
    chk("post_rst_GNT", 8'(bus.GNT), 8'h01);
    bus.REQ = 4'b0000;
    tick();
    tick();

    // Late request during SAMPLE is ignored; dropped request still delivers.
    bus.REQ = 4'b0100;
    expect_word(2'd2);
    tick();
    chk("late_GNT", 8'(bus.GNT), 8'h04);
    bus.REQ    = 4'b1000;
    bus.DREADY = 1'b0;
    tick();
    chk("late_DVALID", 8'(bus.DVALID), 8'h01);
    bus.REQ    = 4'b0000;
    bus.DREADY = 1'b1;
    tick();
    chk("late_done", 8'(bus.DVALID), 8'h00);
    tick();
    chk("late_no_grant", 8'(bus.GNT), 8'h00);
    tick();
    chk("late_no_grant2", 8'(bus.GNT), 8'h00);

    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
